// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// A single full-subtractor slice plus a borrow flop; results and flags register on completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-2:0]  sr_q, sr_d;
    logic              br_q, br_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic              x, y, d, bo;
    logic [WIDTH-1:0]  res;

    assign x   = sa_q[0];
    assign y   = sb_q[0];
    assign d   = x ^ y ^ br_q;
    assign bo  = (~x & y) | (~(x ^ y) & br_q);
    // On the last cycle res holds the complete difference with d as its MSB.
    assign res = {d, sr_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid_i) begin
                    sa_d    = a_i;
                    sb_d    = b_i;
                    br_d    = bin_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                sr_d  = res[WIDTH-1:1];
                br_d  = bo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d  = res;
                    bout_d  = bo;
                    zero_d  = (res == '0);
                    ovf_d   = (x != y) & (d != x);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready_o = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign diff_o        = diff_q;
    assign bout_o        = bout_q;
    assign zero_o        = zero_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed 8-bit vectors, reset abort, held-valid
// handshake, and an exhaustive 4-bit sweep against an arithmetic model.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
        int         dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       sv8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       rdy8, bout8, zero8, ovf8, done8, busy8;
    logic [7:0] diff8;

    logic       sv4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       rdy4, bout4, zero4, ovf4, done4, busy4;
    logic [3:0] diff4;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid_i(sv8), .start_ready_o(rdy8),
        .a_i(a8), .b_i(b8), .bin_i(bin8), .diff_o(diff8), .bout_o(bout8),
        .zero_o(zero8), .ovf_o(ovf8), .done_o(done8), .busy_o(busy8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid_i(sv4), .start_ready_o(rdy4),
        .a_i(a4), .b_i(b4), .bin_i(bin4), .diff_o(diff4), .bout_o(bout4),
        .zero_o(zero4), .ovf_o(ovf4), .done_o(done4), .busy_o(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(e8.diff));
                chk("bout8", 32'(bout8), 32'(e8.bout));
                chk("zero8", 32'(zero8), 32'(e8.zero));
                chk("ovf8", 32'(ovf8), 32'(e8.ovf));
                chk("done8_cycle", 32'(cyc), 32'(e8.dcyc));
                chk("ready8_in_done", 32'(rdy8), 32'd0);
                chk("busy8_in_done", 32'(busy8), 32'd1);
            end
        end
        if (rst_n && done4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done4_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                chk("diff4", 32'(diff4), 32'(e4.diff));
                chk("bout4", 32'(bout4), 32'(e4.bout));
                chk("zero4", 32'(zero4), 32'(e4.zero));
                chk("ovf4", 32'(ovf4), 32'(e4.ovf));
                chk("done4_cycle", 32'(cyc), 32'(e4.dcyc));
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb, input logic ez, input logic eo,
                          input bit push, input bit keep, output int acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready8_timeout", 32'(rdy8), 32'd1);
        a8 = a;
        b8 = b;
        bin8 = bi;
        sv8 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e.diff = ed;
            e.bout = eb;
            e.zero = ez;
            e.ovf = eo;
            e.dcyc = acc + 8;
            q8.push_back(e);
        end
        // Operands are free to change once accepted.
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
        if (!keep) sv8 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bi);
        int n = 0;
        int r, sa, sb, sr;
        exp_t e;
        r = int'(a) - int'(b) - int'(bi);
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        sr = sa - sb - int'(bi);
        e.diff = {4'h0, r[3:0]};
        e.bout = (r < 0);
        e.zero = (r[3:0] == 4'h0);
        e.ovf = (sr < -8) || (sr > 7);
        @(negedge clk);
        while (!rdy4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready4_timeout", 32'(rdy4), 32'd1);
        a4 = a;
        b4 = b;
        bin4 = bi;
        sv4 = 1'b1;
        @(posedge clk);
        #1;
        e.dcyc = cyc + 4;
        q4.push_back(e);
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        sv4 = 1'b0;
    endtask

    task automatic chk_idle8(input string tag);
        chk({tag, "_diff"}, 32'(diff8), 32'd0);
        chk({tag, "_bout"}, 32'(bout8), 32'd0);
        chk({tag, "_zero"}, 32'(zero8), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf8), 32'd0);
        chk({tag, "_done"}, 32'(done8), 32'd0);
        chk({tag, "_busy"}, 32'(busy8), 32'd0);
        chk({tag, "_ready"}, 32'(rdy8), 32'd1);
    endtask

    initial begin
        int acc, last;
        #12;
        chk_idle8("reset8");
        chk("reset4_ready", 32'(rdy4), 32'd1);
        chk("reset4_busy", 32'(busy4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        issue8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        issue8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc);

        // Abort an operation 3 cycles into RUN; zero is 1 from the previous result.
        repeat (12) @(negedge clk);
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle8("midreset");
        @(negedge clk);
        chk_idle8("midreset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_reset_no_done", 32'(done8), 32'd0);
        end
        issue8(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);

        // Held start_valid: back-to-back accepts every WIDTH+2 cycles.
        issue8(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        last = acc;
        issue8(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        chk("accept_spacing_1", 32'(acc - last), 32'd10);
        last = acc;
        issue8(8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk("accept_spacing_2", 32'(acc - last), 32'd10);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    issue4(4'(a), 4'(b), 1'(c));

        for (int i = 0; i < 100 && (q8.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        chk("pending8_drained", 32'(q8.size()), 32'd0);
        chk("pending4_drained", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
